// File: rtl/multicycle_control.sv
// Purpose : Moore control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j, addi).
// Latency : one state per clock; FETCH-to-FETCH lw 5, sw/R-type/addi 4, beq/j 3 cycles.
// Backpr. : none; no stall input, the FSM advances every clock until it parks in ILLEGAL.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   Opcode, Funct       instruction fields from the IR, sampled at the DECODE edge
//   zero, overflow      ALU flags; zero feeds PCEn, overflow is latched in EXEC/ADDIEX
//   RegDst..PCSource    datapath enables and mux selects, decoded from the state register
//   PCEn                PCWrite | (PCWriteCond & zero)
//   ovf_trap            write-back cycle whose register write was suppressed by overflow
//   illegal_op          high while parked in ILLEGAL
//   state               current state, for debug
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       RegDst,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemToReg,
   output logic       ALUSrc,
   output logic       RegWrite,
   output logic [3:0] ALUControl_Signal,
   output logic       IRWrite,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       PCEn,
   output logic       ovf_trap,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC    = 4'd6,
      RWB     = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      ILLEGAL = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   state_t     cur;
   logic       ovf_q;      // overflow seen in the execute step of add/sub/addi
   logic       is_lw_q;    // lw vs sw, captured at DECODE so MEMADR needs no live Opcode
   logic       addsub_q;   // R-type funct is add or sub (the only ones that trap)
   logic [3:0] alu_q;      // EXEC ALU code, captured at DECODE from Funct

   logic       funct_ok;
   logic       funct_addsub;
   logic [3:0] funct_alu;
   logic       pc_write;
   logic       pc_write_cond;

   // R-type funct table
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (Funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         FN_NOR:  funct_alu = ALU_NOR;
         default: funct_ok  = 1'b0;
      endcase
      funct_addsub = (Funct == FN_ADD) || (Funct == FN_SUB);
   end

   // State register plus the few flags the later steps need
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur      <= FETCH;
         ovf_q    <= 1'b0;
         is_lw_q  <= 1'b0;
         addsub_q <= 1'b0;
         alu_q    <= ALU_ADD;
      end else begin
         case (cur)
            FETCH: begin
               cur <= DECODE;
            end
            DECODE: begin
               is_lw_q  <= (Opcode == OP_LW);
               addsub_q <= funct_addsub;
               alu_q    <= funct_alu;
               case (Opcode)
                  OP_LW, OP_SW: cur <= MEMADR;
                  OP_RTYPE:     cur <= funct_ok ? EXEC : ILLEGAL;
                  OP_BEQ:       cur <= BRANCH;
                  OP_J:         cur <= JUMP;
                  OP_ADDI:      cur <= ADDIEX;
                  default:      cur <= ILLEGAL;
               endcase
            end
            MEMADR: begin
               cur <= is_lw_q ? MEMRD : MEMWR;
            end
            MEMRD: begin
               cur <= MEMWB;
            end
            EXEC: begin
               // and/or/slt/nor never trap, so their overflow is ignored
               ovf_q <= overflow & addsub_q;
               cur   <= RWB;
            end
            ADDIEX: begin
               ovf_q <= overflow;
               cur   <= ADDIWB;
            end
            ILLEGAL: begin
               cur <= ILLEGAL;   // parked until reset
            end
            MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB: begin
               cur   <= FETCH;
               ovf_q <= 1'b0;
            end
            default: begin
               // encodings 12-14 are unreachable; recover cleanly if one appears
               cur   <= FETCH;
               ovf_q <= 1'b0;
            end
         endcase
      end
   end

   // Output decode. Reset gates everything so strobes drop asynchronously,
   // even though the state register already reads FETCH during reset.
   always_comb begin
      RegDst            = 1'b0;
      MemRead           = 1'b0;
      MemWrite          = 1'b0;
      MemToReg          = 1'b0;
      RegWrite          = 1'b0;
      ALUControl_Signal = ALU_ADD;
      IRWrite           = 1'b0;
      IorD              = 1'b0;
      ALUSrcA           = 1'b0;
      ALUSrcB           = 2'b00;
      PCSource          = 2'b00;
      pc_write          = 1'b0;
      pc_write_cond     = 1'b0;
      ovf_trap          = 1'b0;
      illegal_op        = 1'b0;
      if (!reset) begin
         case (cur)
            FETCH: begin
               MemRead  = 1'b1;
               IRWrite  = 1'b1;
               pc_write = 1'b1;
               ALUSrcB  = 2'b01;
               PCSource = 2'b00;
            end
            DECODE: begin
               ALUSrcB = 2'b11;   // precompute branch target into ALUOut
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            MEMWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b0;
               MemToReg = 1'b0;
            end
            MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            EXEC: begin
               ALUSrcA           = 1'b1;
               ALUSrcB           = 2'b00;
               ALUControl_Signal = alu_q;
            end
            RWB: begin
               RegDst   = 1'b1;
               MemToReg = 1'b1;
               RegWrite = ~ovf_q;
               ovf_trap = ovf_q;
            end
            BRANCH: begin
               ALUSrcA           = 1'b1;
               ALUSrcB           = 2'b00;
               ALUControl_Signal = ALU_SUB;
               pc_write_cond     = 1'b1;
               PCSource          = 2'b01;
            end
            JUMP: begin
               pc_write = 1'b1;
               PCSource = 2'b10;
            end
            ADDIEX: begin
               ALUSrcA           = 1'b1;
               ALUSrcB           = 2'b10;
               ALUControl_Signal = ALU_ADD;
            end
            ADDIWB: begin
               RegDst   = 1'b0;
               MemToReg = 1'b1;
               RegWrite = ~ovf_q;
               ovf_trap = ovf_q;
            end
            ILLEGAL: begin
               illegal_op = 1'b1;
            end
            default: begin
               illegal_op = 1'b0;
            end
         endcase
      end
   end

   assign ALUSrc = (ALUSrcB == 2'b10);
   assign PCEn   = pc_write | (pc_write_cond & zero);
   assign state  = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : directed check of the multicycle MIPS control FSM against hand-computed values.
// Latency : steps one clock per vector, sampling on the falling edge.
// Backpr. : none; fixed cycle counts plus a time watchdog.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       zero;
   logic       overflow;
   logic       RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
   logic [3:0] ALUControl_Signal;
   logic       IRWrite, IorD, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic       PCEn, ovf_trap, illegal_op;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk               (clk),
      .reset             (reset),
      .Opcode            (Opcode),
      .Funct             (Funct),
      .zero              (zero),
      .overflow          (overflow),
      .RegDst            (RegDst),
      .MemRead           (MemRead),
      .MemWrite          (MemWrite),
      .MemToReg          (MemToReg),
      .ALUSrc            (ALUSrc),
      .RegWrite          (RegWrite),
      .ALUControl_Signal (ALUControl_Signal),
      .IRWrite           (IRWrite),
      .IorD              (IorD),
      .ALUSrcA           (ALUSrcA),
      .ALUSrcB           (ALUSrcB),
      .PCSource          (PCSource),
      .PCEn              (PCEn),
      .ovf_trap          (ovf_trap),
      .illegal_op        (illegal_op),
      .state             (state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic any_write();
      return RegWrite | MemWrite | MemRead | IRWrite | PCEn;
   endfunction

   // R-type vectors: funct, expected ALU code, overflow in EXEC, expected RegWrite/ovf_trap in RWB
   logic [5:0] rt_funct [7] = '{6'b100000, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
   logic [3:0] rt_alu   [7] = '{4'b0010,   4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};
   logic       rt_ovf   [7] = '{1'b1,      1'b0,      1'b1,      1'b1,      1'b0,      1'b1,      1'b0};
   logic       rt_wr    [7] = '{1'b0,      1'b1,      1'b0,      1'b1,      1'b1,      1'b1,      1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      Opcode   = 6'b000000;
      Funct    = 6'b000000;
      zero     = 1'b0;
      overflow = 1'b0;

      // ---- reset state ----
      cyc();
      check_eq("rst_state", 32'(state), 0);
      check_eq("rst_writes", 32'(any_write()), 0);
      check_eq("rst_alu", 32'(ALUControl_Signal), 32'h2);
      zero = 1'b1;
      #1;
      check_eq("rst_pcen_zero", 32'(PCEn), 0);
      zero = 1'b0;
      cyc();
      reset = 1'b0;
      #1;
      check_eq("fetch_state", 32'(state), 0);
      check_eq("fetch_irwrite", 32'(IRWrite), 1);
      check_eq("fetch_memread", 32'(MemRead), 1);
      check_eq("fetch_pcen", 32'(PCEn), 1);
      check_eq("fetch_srcb", 32'(ALUSrcB), 1);
      check_eq("fetch_pcsrc", 32'(PCSource), 0);

      // ---- lw: 0,1,2,3,4,0 ----
      Opcode = 6'b100011;
      cyc();
      check_eq("lw_decode", 32'(state), 1);
      check_eq("lw_decode_srcb", 32'(ALUSrcB), 3);
      check_eq("lw_decode_writes", 32'(any_write()), 0);
      cyc();
      check_eq("lw_memadr", 32'(state), 2);
      check_eq("lw_memadr_srca", 32'(ALUSrcA), 1);
      check_eq("lw_memadr_srcb", 32'(ALUSrcB), 2);
      check_eq("lw_memadr_alusrc", 32'(ALUSrc), 1);
      cyc();
      check_eq("lw_memrd", 32'(state), 3);
      check_eq("lw_memrd_read", 32'(MemRead), 1);
      check_eq("lw_memrd_iord", 32'(IorD), 1);
      check_eq("lw_memrd_regwrite", 32'(RegWrite), 0);
      cyc();
      check_eq("lw_memwb", 32'(state), 4);
      check_eq("lw_memwb_regwrite", 32'(RegWrite), 1);
      check_eq("lw_memwb_memtoreg", 32'(MemToReg), 0);
      check_eq("lw_memwb_regdst", 32'(RegDst), 0);
      check_eq("lw_memwb_memread", 32'(MemRead), 0);
      cyc();
      check_eq("lw_back_fetch", 32'(state), 0);

      // ---- reset mid-MEMRD ----
      cyc();
      cyc();
      cyc();
      check_eq("mrst_in_memrd", 32'(state), 3);
      #2;
      reset = 1'b1;
      #1;
      check_eq("mrst_state", 32'(state), 0);
      check_eq("mrst_memread", 32'(MemRead), 0);
      check_eq("mrst_iord", 32'(IorD), 0);
      check_eq("mrst_writes", 32'(any_write()), 0);
      cyc();
      #3;
      check_eq("mrst_hold_writes", 32'(any_write()), 0);
      reset = 1'b0;
      #1;
      check_eq("mrst_rel_state", 32'(state), 0);
      check_eq("mrst_rel_irwrite", 32'(IRWrite), 1);
      cyc();
      check_eq("mrst_rel_decode", 32'(state), 1);
      cyc(); cyc(); cyc(); cyc();
      check_eq("mrst_lw_done", 32'(state), 0);

      // ---- R-type table ----
      for (int i = 0; i < 7; i++) begin
         Opcode = 6'b000000;
         Funct  = rt_funct[i];
         check_eq($sformatf("rt%0d_fetch", i), 32'(state), 0);
         cyc();
         check_eq($sformatf("rt%0d_decode", i), 32'(state), 1);
         cyc();
         check_eq($sformatf("rt%0d_exec", i), 32'(state), 6);
         check_eq($sformatf("rt%0d_alu", i), 32'(ALUControl_Signal), 32'(rt_alu[i]));
         check_eq($sformatf("rt%0d_srca", i), 32'(ALUSrcA), 1);
         check_eq($sformatf("rt%0d_srcb", i), 32'(ALUSrcB), 0);
         overflow = rt_ovf[i];
         cyc();
         overflow = 1'b0;
         check_eq($sformatf("rt%0d_rwb", i), 32'(state), 7);
         check_eq($sformatf("rt%0d_regwrite", i), 32'(RegWrite), 32'(rt_wr[i]));
         check_eq($sformatf("rt%0d_trap", i), 32'(ovf_trap), 32'(!rt_wr[i]));
         check_eq($sformatf("rt%0d_regdst", i), 32'(RegDst), 1);
         check_eq($sformatf("rt%0d_memtoreg", i), 32'(MemToReg), 1);
         cyc();
         check_eq($sformatf("rt%0d_back_fetch", i), 32'(state), 0);
         check_eq($sformatf("rt%0d_trap_clr", i), 32'(ovf_trap), 0);
      end

      // ---- addi with and without overflow ----
      for (int k = 0; k < 2; k++) begin
         Opcode = 6'b001000;
         cyc();
         check_eq("addi_decode", 32'(state), 1);
         cyc();
         check_eq("addi_ex", 32'(state), 10);
         check_eq("addi_ex_srcb", 32'(ALUSrcB), 2);
         check_eq("addi_ex_alusrc", 32'(ALUSrc), 1);
         check_eq("addi_ex_alu", 32'(ALUControl_Signal), 32'h2);
         overflow = (k == 0);
         cyc();
         overflow = 1'b0;
         check_eq("addi_wb", 32'(state), 11);
         check_eq("addi_wb_regwrite", 32'(RegWrite), (k == 0) ? 0 : 1);
         check_eq("addi_wb_trap", 32'(ovf_trap), (k == 0) ? 1 : 0);
         check_eq("addi_wb_regdst", 32'(RegDst), 0);
         check_eq("addi_wb_memtoreg", 32'(MemToReg), 1);
         cyc();
         check_eq("addi_back_fetch", 32'(state), 0);
      end

      // ---- beq taken / not taken ----
      for (int k = 0; k < 2; k++) begin
         Opcode = 6'b000100;
         cyc();
         check_eq("beq_decode", 32'(state), 1);
         cyc();
         check_eq("beq_branch", 32'(state), 8);
         check_eq("beq_alu", 32'(ALUControl_Signal), 32'h6);
         check_eq("beq_pcsrc", 32'(PCSource), 1);
         zero = (k == 0);
         #1;
         check_eq("beq_pcen", 32'(PCEn), (k == 0) ? 1 : 0);
         zero = 1'b0;
         cyc();
         check_eq("beq_back_fetch", 32'(state), 0);
      end

      // ---- sw ----
      Opcode = 6'b101011;
      cyc();
      check_eq("sw_decode_memwrite", 32'(MemWrite), 0);
      cyc();
      check_eq("sw_memadr", 32'(state), 2);
      check_eq("sw_memadr_memwrite", 32'(MemWrite), 0);
      cyc();
      check_eq("sw_memwr", 32'(state), 5);
      check_eq("sw_memwr_memwrite", 32'(MemWrite), 1);
      check_eq("sw_memwr_iord", 32'(IorD), 1);
      check_eq("sw_memwr_regwrite", 32'(RegWrite), 0);
      cyc();
      check_eq("sw_back_fetch", 32'(state), 0);
      check_eq("sw_fetch_memwrite", 32'(MemWrite), 0);

      // ---- j ----
      Opcode = 6'b000010;
      cyc();
      cyc();
      check_eq("j_jump", 32'(state), 9);
      check_eq("j_pcen", 32'(PCEn), 1);
      check_eq("j_pcsrc", 32'(PCSource), 2);
      cyc();
      check_eq("j_back_fetch", 32'(state), 0);

      // ---- illegal opcode, then illegal funct ----
      for (int k = 0; k < 2; k++) begin
         Opcode = (k == 0) ? 6'b111111 : 6'b000000;
         Funct  = 6'b000000;
         cyc();
         check_eq("ill_decode", 32'(state), 1);
         cyc();
         check_eq("ill_state", 32'(state), 15);
         check_eq("ill_flag", 32'(illegal_op), 1);
         for (int n = 0; n < 20; n++) begin
            cyc();
            check_eq($sformatf("ill%0d_hold_%0d", k, n), 32'(state), 15);
            check_eq($sformatf("ill%0d_nowrite_%0d", k, n), 32'(any_write() | illegal_op ^ 1'b1), 0);
         end
         reset = 1'b1;
         cyc();
         check_eq("ill_rst_flag", 32'(illegal_op), 0);
         check_eq("ill_rst_state", 32'(state), 0);
         reset = 1'b0;
         #1;
         check_eq("ill_rec_irwrite", 32'(IRWrite), 1);
         cyc();
         check_eq("ill_rec_decode", 32'(state), 1);
         Opcode = 6'b000010;
         cyc();
         cyc();
         check_eq("ill_rec_fetch", 32'(state), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
